dfr_phase_sequencer: RTL and testbench

DFR_PHASE_SEQUENCER -- requirements
Module: dfr_phase_sequencer

---
 rtl/dfr_pkg.sv | 32 +++
 rtl/dfr_step_counter.sv | 23 ++
 rtl/dfr_phase_sequencer.sv | 142 ++++++++++++++
 tb/tb_dfr_phase_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfr_pkg.sv
// Shared types for the DFR phase sequencer: FSM states, phase encodings,
// phase_en bit positions and the next-runnable-phase helper.
package dfr_pkg;

  localparam int NUM_PH   = 3;
  localparam int EN_INIT  = 0;
  localparam int EN_TRAIN = 1;
  localparam int EN_TEST  = 2;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_INIT  = 2'd1;
  localparam logic [1:0] PH_TRAIN = 2'd2;
  localparam logic [1:0] PH_TEST  = 2'd3;

  // Run states share their low bits with the phase encoding.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_TRAIN  = 3'd2,
    S_TEST   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  // First runnable phase with index >= from, or FINISH when none remain.
  function automatic state_t first_runnable(input logic [NUM_PH-1:0] runnable,
                                             input int from);
    first_runnable = S_FINISH;
    for (int i = NUM_PH - 1; i >= 0; i--)
      if (i >= from && runnable[i]) first_runnable = state_t'(3'(i + 1));
  endfunction

endpackage

// File: rtl/dfr_step_counter.sv
// Up-counter with synchronous clear, enable, wrap at limit and a
// terminal-count flag that is high while count equals limit.
module dfr_step_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  assign tc = (count == limit);

  always_ff @(posedge clk) begin
    if (rst || load)  count <= '0;
    else if (en)      count <= tc ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/dfr_phase_sequencer.sv
// Walks the enabled INIT/TRAIN/TEST phases, issuing one step request per
// handshake with global step and per-phase sample addressing.
module dfr_phase_sequencer
  import dfr_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int COUNT_WIDTH = 32,
  parameter int NUM_PHASES  = 3
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_PHASES-1:0]  phase_en,
  input  logic [COUNT_WIDTH-1:0] num_init_steps,
  input  logic [COUNT_WIDTH-1:0] num_train_steps,
  input  logic [COUNT_WIDTH-1:0] num_test_steps,
  input  logic [COUNT_WIDTH-1:0] num_steps_per_sample,
  output logic                   step_valid,
  input  logic                   step_ready,
  output logic [ADDR_WIDTH-1:0]  step_addr,
  output logic [ADDR_WIDTH-1:0]  sample_addr,
  output logic                   sample_done,
  output logic [1:0]             phase,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  state_t state, state_nx;

  logic [NUM_PHASES-1:0]  en_q;
  logic [COUNT_WIDTH-1:0] init_q, train_q, test_q, sps_q;
  logic [COUNT_WIDTH-1:0] phase_lim;
  logic [NUM_PHASES-1:0]  run_in, run_q;
  logic running, accept, hs, load, sample_tc, phase_tc;

  assign run_in = phase_en & {num_test_steps != '0, num_train_steps != '0,
                              num_init_steps != '0};
  assign run_q  = en_q & {test_q != '0, train_q != '0, init_q != '0};

  assign running = (state == S_INIT) || (state == S_TRAIN) || (state == S_TEST);
  assign accept  = (state == S_IDLE) && start && !abort &&
                   (num_steps_per_sample != '0);
  // abort wins over a coincident handshake: the step is dropped here.
  assign hs      = running && step_ready && !abort;
  assign load    = (state_nx != state);

  always_comb begin
    phase_lim = '0;
    case (state)
      S_INIT:  phase_lim = init_q - 1'b1;
      S_TRAIN: phase_lim = train_q - 1'b1;
      S_TEST:  phase_lim = test_q - 1'b1;
      default: phase_lim = '0;
    endcase
  end

  dfr_step_counter #(.W(COUNT_WIDTH)) u_sample_cnt (
    .clk   (S_AXI_ACLK),
    .rst   (rst),
    .load  (load),
    .en    (hs),
    .limit (sps_q - 1'b1),
    .tc    (sample_tc)
  );

  dfr_step_counter #(.W(COUNT_WIDTH)) u_phase_cnt (
    .clk   (S_AXI_ACLK),
    .rst   (rst),
    .load  (load),
    .en    (hs),
    .limit (phase_lim),
    .tc    (phase_tc)
  );

  always_ff @(posedge S_AXI_ACLK) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    step_valid  = 1'b0;
    sample_done = 1'b0;
    done        = 1'b0;
    busy        = (state != S_IDLE);
    phase       = PH_IDLE;
    case (state)
      S_IDLE: if (accept) state_nx = first_runnable(run_in, 0);
      S_INIT, S_TRAIN, S_TEST: begin
        step_valid  = 1'b1;
        phase       = state[1:0];
        sample_done = hs && sample_tc;
        if (abort)                 state_nx = S_IDLE;
        else if (hs && phase_tc)   state_nx = first_runnable(run_q, int'(state));
      end
      S_FINISH: begin
        done     = !abort;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (rst) begin
      en_q    <= '0;
      init_q  <= '0;
      train_q <= '0;
      test_q  <= '0;
      sps_q   <= '0;
    end else if (accept) begin
      en_q    <= phase_en;
      init_q  <= num_init_steps;
      train_q <= num_train_steps;
      test_q  <= num_test_steps;
      sps_q   <= num_steps_per_sample;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (rst)
      cfg_err <= 1'b0;
    else if (state == S_IDLE && start && !abort)
      cfg_err <= (num_steps_per_sample == '0);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (rst)         step_addr <= '0;
    else if (accept) step_addr <= '0;
    else if (hs)     step_addr <= step_addr + 1'b1;
  end

  // Phase entry (any state change) restarts sample numbering.
  always_ff @(posedge S_AXI_ACLK) begin
    if (rst)                  sample_addr <= '0;
    else if (load)            sample_addr <= '0;
    else if (hs && sample_tc) sample_addr <= sample_addr + 1'b1;
  end

endmodule

// File: tb/tb_dfr_phase_sequencer.sv
// Scoreboard bench: every expected handshake is queued at launch and
// compared against the DUT when the handshake occurs.
module tb_dfr_phase_sequencer;

  localparam int AW = 16;
  localparam int CW = 32;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, step_ready = 1'b1;
  logic [2:0]    phase_en = '0;
  logic [CW-1:0] n_init = '0, n_train = '0, n_test = '0, sps = '0;
  logic          step_valid, sample_done, busy, done, cfg_err;
  logic [AW-1:0] step_addr, sample_addr;
  logic [1:0]    phase;

  dfr_phase_sequencer #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .NUM_PHASES(3)) dut (
    .S_AXI_ACLK           (clk),
    .rst                  (rst),
    .start                (start),
    .abort                (abort),
    .phase_en             (phase_en),
    .num_init_steps       (n_init),
    .num_train_steps      (n_train),
    .num_test_steps       (n_test),
    .num_steps_per_sample (sps),
    .step_valid           (step_valid),
    .step_ready           (step_ready),
    .step_addr            (step_addr),
    .sample_addr          (sample_addr),
    .sample_done          (sample_done),
    .phase                (phase),
    .busy                 (busy),
    .done                 (done),
    .cfg_err              (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] step;
    logic [AW-1:0] smp;
    logic [1:0]    ph;
    logic          sd;
  } exp_t;

  exp_t exq[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, hs_cnt = 0, sd_cnt = 0, done_cnt = 0, done_cyc = -1, start_cyc = 0;
  bit   rnd = 0;
  logic prev_stall = 1'b0;
  logic [AW-1:0] prev_step = '0, prev_smp = '0;

  task automatic mon();
    exp_t e;
    if (step_valid === 1'b1 && step_ready && !abort && !rst) begin
      hs_cnt++;
      if (sample_done === 1'b1) sd_cnt++;
      checks++;
      if (exq.size() == 0) begin
        errors++;
        $display("FAIL hs_unexpected: handshake at step_addr=%0d, required none", step_addr);
      end else begin
        e = exq.pop_front();
        if (step_addr !== e.step || sample_addr !== e.smp || phase !== e.ph || sample_done !== e.sd) begin
          errors++;
          $display("FAIL hs_fields: step/sample/phase/sdone=%0d/%0d/%0d/%0b, required %0d/%0d/%0d/%0b",
                   step_addr, sample_addr, phase, sample_done, e.step, e.smp, e.ph, e.sd);
        end
      end
    end else if (sample_done === 1'b1 && !rst) begin
      checks++; errors++;
      $display("FAIL sample_done_spurious: sample_done=1 without handshake, required 0");
    end
    if (prev_stall) begin
      checks++;
      if (step_addr !== prev_step || sample_addr !== prev_smp) begin
        errors++;
        $display("FAIL stall_hold: step/sample=%0d/%0d, required %0d/%0d",
                 step_addr, sample_addr, prev_step, prev_smp);
      end
    end
    prev_stall = (step_valid === 1'b1) && !step_ready && !abort && !rst;
    prev_step  = step_addr;
    prev_smp   = sample_addr;
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
  endtask

  task automatic step_cyc();
    cyc++;
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    if (rnd) step_ready = ($urandom_range(0, 1) == 1);
  endtask

  // Reference model: phases in order, global address, sample = k / sps.
  task automatic push_model(input logic [2:0] en, input int ci, input int ct, input int cs, input int s);
    int a;
    int c[3];
    a = 0;
    c = '{ci, ct, cs};
    for (int p = 0; p < 3; p++)
      if (en[p] && c[p] > 0)
        for (int k = 0; k < c[p]; k++) begin
          exp_t e;
          e.step = AW'(a);
          e.smp  = AW'(k / s);
          e.ph   = 2'(p + 1);
          e.sd   = ((k % s) == s - 1);
          exq.push_back(e);
          a++;
        end
  endtask

  task automatic launch(input logic [2:0] en, input int ci, input int ct, input int cs,
                        input int s, input bit push);
    phase_en = en; n_init = ci; n_train = ct; n_test = cs; sps = s;
    hs_cnt = 0; sd_cnt = 0; done_cnt = 0; done_cyc = -1;
    start_cyc = cyc + 1;
    if (push) push_model(en, ci, ct, cs, s);
    start = 1'b1;
    step_cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin step_cyc(); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step_cyc();
    checks++;
    if ({step_valid, step_addr, sample_addr, sample_done, phase, busy, done, cfg_err} !== '0) begin
      errors++;
      $display("FAIL reset_values: v=%b sa=%0d sm=%0d sd=%b ph=%0d busy=%b done=%b err=%b, required all 0",
               step_valid, step_addr, sample_addr, sample_done, phase, busy, done, cfg_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_phase();
    launch(3'b100, 0, 0, 50, 10, 1);
    wait_idle(200);
    checks++;
    if (hs_cnt != 50 || sd_cnt != 5 || done_cnt != 1 || done_cyc - start_cyc != 51 || exq.size() != 0) begin
      errors++;
      $display("FAIL single_phase: hs=%0d sd=%0d done=%0d lat=%0d left=%0d, required 50/5/1/51/0",
               hs_cnt, sd_cnt, done_cnt, done_cyc - start_cyc, exq.size());
    end
  endtask

  task automatic test_all_phases();
    launch(3'b111, 10, 20, 10, 10, 1);
    wait_idle(200);
    checks++;
    if (hs_cnt != 40 || sd_cnt != 4 || done_cnt != 1 || done_cyc - start_cyc != 41 || exq.size() != 0) begin
      errors++;
      $display("FAIL all_phases: hs=%0d sd=%0d done=%0d lat=%0d left=%0d, required 40/4/1/41/0",
               hs_cnt, sd_cnt, done_cnt, done_cyc - start_cyc, exq.size());
    end
    // Zero-count TRAIN must be skipped without an idle cycle.
    launch(3'b111, 5, 0, 5, 5, 1);
    wait_idle(100);
    checks++;
    if (hs_cnt != 10 || sd_cnt != 2 || done_cnt != 1 || done_cyc - start_cyc != 11 || exq.size() != 0) begin
      errors++;
      $display("FAIL skip_zero: hs=%0d sd=%0d done=%0d lat=%0d left=%0d, required 10/2/1/11/0",
               hs_cnt, sd_cnt, done_cnt, done_cyc - start_cyc, exq.size());
    end
  endtask

  task automatic test_cfg_err();
    launch(3'b100, 0, 0, 5, 0, 0);
    checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_set: cfg_err=%b busy=%b, required 1/0", cfg_err, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step_cyc();
      checks++;
      if (busy !== 1'b0 || cfg_err !== 1'b1) begin
        errors++;
        $display("FAIL cfg_err_hold: busy=%b cfg_err=%b, required 0/1", busy, cfg_err);
      end
    end
    launch(3'b100, 0, 0, 5, 5, 1);
    checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_clear: cfg_err=%b busy=%b, required 0/1", cfg_err, busy);
    end
    wait_idle(50);
    checks++;
    if (hs_cnt != 5 || sd_cnt != 1 || done_cnt != 1 || exq.size() != 0) begin
      errors++;
      $display("FAIL cfg_err_run: hs=%0d sd=%0d done=%0d left=%0d, required 5/1/1/0",
               hs_cnt, sd_cnt, done_cnt, exq.size());
    end
  endtask

  task automatic test_stall();
    rnd = 1;
    launch(3'b100, 0, 0, 23, 10, 1);
    wait_idle(1000);
    rnd = 0;
    step_ready = 1'b1;
    checks++;
    if (hs_cnt != 23 || sd_cnt != 2 || done_cnt != 1 || exq.size() != 0) begin
      errors++;
      $display("FAIL stall_run: hs=%0d sd=%0d done=%0d left=%0d, required 23/2/1/0",
               hs_cnt, sd_cnt, done_cnt, exq.size());
    end
  endtask

  task automatic test_abort_reset();
    int n;
    launch(3'b100, 0, 0, 50, 10, 1);
    n = 0;
    while (hs_cnt < 16 && n < 200) begin step_cyc(); n++; end
    abort = 1'b1;
    step_cyc();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || step_valid !== 1'b0 || phase !== 2'd0 || hs_cnt != 16) begin
      errors++;
      $display("FAIL abort_state: busy=%b valid=%b phase=%0d hs=%0d, required 0/0/0/16",
               busy, step_valid, phase, hs_cnt);
    end
    repeat (3) step_cyc();
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done=%0d busy=%b, required 0/0", done_cnt, busy);
    end
    exq.delete();

    launch(3'b100, 0, 0, 50, 10, 1);
    n = 0;
    while (hs_cnt < 30 && n < 200) begin step_cyc(); n++; end
    rst = 1'b1;
    step_cyc();
    rst = 1'b0;
    checks++;
    if ({step_valid, step_addr, sample_addr, sample_done, phase, busy, done, cfg_err} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: v=%b sa=%0d sm=%0d sd=%b ph=%0d busy=%b done=%b err=%b, required all 0",
               step_valid, step_addr, sample_addr, sample_done, phase, busy, done, cfg_err);
    end
    exq.delete();
    repeat (2) step_cyc();
    checks++;
    if (busy !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL reset_stays_idle: busy=%b done=%0d, required 0/0", busy, done_cnt);
    end
  endtask

  task automatic test_empty_and_busy_start();
    launch(3'b000, 5, 5, 5, 10, 1);
    wait_idle(10);
    checks++;
    if (done_cnt != 1 || done_cyc != start_cyc + 1 || hs_cnt != 0) begin
      errors++;
      $display("FAIL empty_run: done=%0d lat=%0d hs=%0d, required 1/1/0",
               done_cnt, done_cyc - start_cyc, hs_cnt);
    end
    launch(3'b100, 0, 0, 20, 5, 1);
    repeat (5) step_cyc();
    phase_en = 3'b001; n_init = 7; sps = 3;
    start = 1'b1;
    step_cyc();
    start = 1'b0;
    wait_idle(100);
    checks++;
    if (hs_cnt != 20 || sd_cnt != 4 || done_cnt != 1 || exq.size() != 0) begin
      errors++;
      $display("FAIL busy_start: hs=%0d sd=%0d done=%0d left=%0d, required 20/4/1/0",
               hs_cnt, sd_cnt, done_cnt, exq.size());
    end
  endtask

  task automatic test_back_to_back();
    // TRAIN disabled; TEST ends on a partial sample.
    launch(3'b101, 4, 9, 6, 4, 1);
    wait_idle(100);
    checks++;
    if (hs_cnt != 10 || sd_cnt != 2 || done_cnt != 1 || done_cyc - start_cyc != 11 || exq.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: hs=%0d sd=%0d done=%0d lat=%0d left=%0d, required 10/2/1/11/0",
               hs_cnt, sd_cnt, done_cnt, done_cyc - start_cyc, exq.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_phase();
    test_all_phases();
    test_cfg_err();
    test_stall();
    test_abort_reset();
    test_empty_and_busy_start();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
